wb_commit: RTL
==============

WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 Parameter TLBNUM, default 16, number of TLB entries; SHALL be a power of two, 2..256; IDX_W = clog2(TLBNUM).
REQ-002 Parameter FILL_MODE, default 0, TLBFILL index policy: 0 = round-robin pointer, 1 = LFSR pseudo-random.
REQ-003 Parameter TLB_LAT, default 1, cycles a TLB-op instruction occupies the stage (1..8).
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  MEM stage holds a valid instruction on in_bus.
REQ-007 in_allowin  out  1  stage accepts in_bus this cycle.
REQ-008 in_bus  in  202  MSB-first: pc32, rf_we1, rf_waddr5, rf_wdata32, csr_re1, csr_we1, csr_num14, csr_wmask32, csr_wvalue32, ex1, ecode6, esubcode9, ertn1, vaddr32, tlb_op3.
REQ-009 csr_rvalue  in  32  CSR read data for the held csr_num.
REQ-010 csr_tlbidx_index  in  IDX_W  TLBIDX.Index, used by TLBWR.
REQ-011 rf_we / rf_waddr / rf_wdata  out  1/5/32  register-file write port and ID forwarding.
REQ-012 csr_re  out  1  held csr_re; csr_bus  out  79  {csr_we, csr_num, csr_wmask, csr_wvalue}.
REQ-013 exc_bus  out  81  {ex_valid, ertn, ecode, esubcode, pc, vaddr}.
REQ-014 flush  out  1  pipeline flush request to earlier stages.
REQ-015 tlb_we  out  1  TLB write strobe; tlb_w_index  out  IDX_W  write index.
REQ-016 tlbrd_en  out  1  TLBRD strobe to CSR file.
REQ-017 commit_cnt  out  32  committed-instruction counter.

Function
REQ-018 One register slot; valid bit v; all in_bus fields latched when in_valid & in_allowin & ~flush.
REQ-019 tlb_op encoding: 0 NONE, 1 SRCH, 2 RD, 3 WR, 4 FILL, 5 INV; 6,7 treated as NONE.
REQ-020 Occupancy counter occ (3 bits): cleared on every load; increments each cycle v & tlb_op in 1..5 & ~ready_go.
REQ-021 ready_go = (tlb_op not in 1..5) | (occ == TLB_LAT-1); TLB_LAT=1 gives zero stall.
REQ-022 in_allowin = ~v | (ready_go & ~flush).
REQ-023 flush = v & (ex | ertn), asserted from the first held cycle, independent of ready_go; next cycle v <= 0, in_bus that cycle discarded.
REQ-024 commit = v & ready_go & ~ex & ~ertn; single-cycle per instruction.
REQ-025 rf_we = commit & held rf_we; rf_wdata = csr_re ? csr_rvalue : held rf_wdata.
REQ-026 csr_bus.csr_we = commit & held csr_we; other csr_bus fields are held values.
REQ-027 exc_bus.ex_valid = v & ex; exc_bus.ertn = v & ertn; remaining fields held values.
REQ-028 tlb_we = commit & tlb_op in {WR, FILL}; tlbrd_en = commit & tlb_op == RD; SRCH/INV only consume latency.
REQ-029 tlb_w_index = FILL ? fill_idx : csr_tlbidx_index.
REQ-030 FILL_MODE 0: fill_idx = ptr; ptr += 1 on each FILL commit, wrapping TLBNUM-1 -> 0.
REQ-031 FILL_MODE 1: 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'h01, steps every cycle; fill_idx = lfsr[IDX_W-1:0].
REQ-032 commit_cnt += 1 on every commit, wraps 32'hFFFFFFFF -> 0.
REQ-033 in_valid while v & ~ready_go: held instruction unchanged, in_bus ignored.

Reset
REQ-034 On ~resetn: v=0, occ=0, ptr=0, lfsr=8'h01, commit_cnt=0, all held fields 0; hence every strobe output 0 and in_allowin=1.
REQ-035 Reset mid-stall drops the held instruction with no strobe; reset has priority over load and flush.

Verification
REQ-036 ADD commit, rf_we=1, waddr=5, wdata=0x1234 -> rf_we=1 one cycle after acceptance, commit_cnt=1.
REQ-037 TLB_LAT=3, TLBWR, csr_tlbidx_index=7 -> in_allowin=0 for 2 cycles, single tlb_we pulse with tlb_w_index=7 on 3rd.
REQ-038 FILL_MODE 0, TLBNUM=16, 17 TLBFILLs -> indices 0..15 then 0.
REQ-039 ex=1, ecode=0x3F, back-to-back next instruction -> flush=1, ex_valid=1, no rf_we/csr_we/tlb_we, next instruction discarded, commit_cnt unchanged.
REQ-040 CSRRD csr_re=1, csr_rvalue=0xDEADBEEF -> rf_wdata=0xDEADBEEF; resetn=0 during TLB_LAT=3 stall -> no tlb_we, commit_cnt=0.

Source files
------------

// File: rtl/wb_commit_if.sv
// MEM -> WB handoff: valid/allowin handshake plus the 202-bit instruction bus.
interface wb_commit_if;
    logic         in_valid;
    logic         in_allowin;
    logic [201:0] in_bus;

    modport master (output in_valid, output in_bus, input in_allowin);
    modport slave  (input in_valid, input in_bus, output in_allowin);
endinterface

// File: rtl/wb_commit.sv
// Write-back/commit stage: a single-slot instruction holder that stalls TLB ops for TLB_LAT
// cycles, raises a flush on exceptions/ertn, and emits the register, CSR and TLB commit strobes.
module wb_commit #(
    parameter int  TLBNUM    = 16,
    parameter int  FILL_MODE = 0,
    parameter int  TLB_LAT   = 1,
    localparam int IDX_W     = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             resetn,
    wb_commit_if.slave       in_if,
    input  logic [31:0]      csr_rvalue_i,
    input  logic [IDX_W-1:0] csr_tlbidx_index_i,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [31:0]      rf_wdata_o,
    output logic             csr_re_o,
    output logic [78:0]      csr_bus_o,
    output logic [80:0]      exc_bus_o,
    output logic             flush_o,
    output logic             tlb_we_o,
    output logic [IDX_W-1:0] tlb_w_index_o,
    output logic             tlbrd_en_o,
    output logic [31:0]      commit_cnt_o
);

    localparam logic [2:0] OP_SRCH  = 3'd1;
    localparam logic [2:0] OP_RD    = 3'd2;
    localparam logic [2:0] OP_WR    = 3'd3;
    localparam logic [2:0] OP_FILL  = 3'd4;
    localparam logic [2:0] OP_INV   = 3'd5;
    localparam logic [2:0] OCC_LAST = 3'(TLB_LAT - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        ertn;
        logic [31:0] vaddr;
        logic [2:0]  tlb_op;
    } inst_t;

    inst_t            inst_q, inst_d;
    logic             v_q, v_d;
    logic [2:0]       occ_q, occ_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [31:0]      cnt_q, cnt_d;

    logic             tlb_busy;
    logic             ready_go;
    logic             flush;
    logic             commit;
    logic             allowin;
    logic             load;
    logic             is_fill;
    logic [IDX_W-1:0] fill_idx;

    // Only SRCH..INV occupy the stage; codes 6 and 7 behave like NONE.
    assign tlb_busy = (inst_q.tlb_op >= OP_SRCH) && (inst_q.tlb_op <= OP_INV);
    assign ready_go = ~tlb_busy | (occ_q == OCC_LAST);
    assign flush    = v_q & (inst_q.ex | inst_q.ertn);
    assign commit   = v_q & ready_go & ~inst_q.ex & ~inst_q.ertn;
    assign allowin  = ~v_q | (ready_go & ~flush);
    assign load     = in_if.in_valid & allowin & ~flush;
    assign is_fill  = (inst_q.tlb_op == OP_FILL);
    assign fill_idx = (FILL_MODE == 1) ? lfsr_q[IDX_W-1:0] : ptr_q;

    assign in_if.in_allowin = allowin;

    always_comb begin
        inst_d = inst_q;
        v_d    = v_q & ~ready_go & ~flush;
        occ_d  = occ_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (v_q && tlb_busy && !ready_go) begin
            occ_d = occ_q + 3'd1;
        end
        if (load) begin
            inst_d = inst_t'(in_if.in_bus);
            v_d    = 1'b1;
            occ_d  = 3'd0;
        end
        if (commit) begin
            cnt_d = cnt_q + 32'd1;
            if (is_fill) begin
                ptr_d = ptr_q + IDX_W'(1);
            end
        end
    end

    // Reset wins over load and flush; a stalled instruction is simply dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            inst_q <= '0;
            v_q    <= 1'b0;
            occ_q  <= 3'd0;
            ptr_q  <= '0;
            lfsr_q <= 8'h01;
            cnt_q  <= 32'd0;
        end else begin
            inst_q <= inst_d;
            v_q    <= v_d;
            occ_q  <= occ_d;
            ptr_q  <= ptr_d;
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rf_we_o       = commit & inst_q.rf_we;
    assign rf_waddr_o    = inst_q.rf_waddr;
    assign rf_wdata_o    = inst_q.csr_re ? csr_rvalue_i : inst_q.rf_wdata;
    assign csr_re_o      = inst_q.csr_re;
    assign csr_bus_o     = {commit & inst_q.csr_we, inst_q.csr_num,
                            inst_q.csr_wmask, inst_q.csr_wvalue};
    assign exc_bus_o     = {v_q & inst_q.ex, v_q & inst_q.ertn, inst_q.ecode,
                            inst_q.esubcode, inst_q.pc, inst_q.vaddr};
    assign flush_o       = flush;
    assign tlb_we_o      = commit & ((inst_q.tlb_op == OP_WR) | is_fill);
    assign tlb_w_index_o = is_fill ? fill_idx : csr_tlbidx_index_i;
    assign tlbrd_en_o    = commit & (inst_q.tlb_op == OP_RD);
    assign commit_cnt_o  = cnt_q;

endmodule
